memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum cycles an access waits for dmem_ack (used only when MEM_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have EX/MEM inputs: RegWr_EX 1, MemWr_EX 1, MemRd_EX 1, WBdata_EX 2, ALUout 32 (address/result), D 32 (store data), npc3 32, rd3 4.
REQ-005 SHALL have data-memory outputs: dmem_req 1, dmem_we 1, dmem_addr 32, dmem_wdata 32.
REQ-006 SHALL have data-memory inputs: dmem_rdata 32 and dmem_ack 1, where ack completes the current request.
REQ-007 SHALL have output stall_mem, 1 bit: upstream holds EX/MEM contents while it is high.
REQ-008 SHALL have MEM/WB outputs (registered): RegWr_MEM 1, WBdata_MEM 2, ALUout4 32, MemData4 32, npc4 32, rd4 4.
REQ-009 SHALL have output mem_err, 1 bit: sticky timeout flag.

Function
REQ-010 SHALL define access = MemRd_EX | MemWr_EX, with store taking priority when both are high, so no read data is captured.
REQ-011 SHALL implement a two-state FSM: IDLE, WAIT.
REQ-012 SHALL drive dmem_req = access whenever the FSM is in IDLE or WAIT; dmem_addr = ALUout, dmem_wdata = D, dmem_we = MemWr_EX (combinational).
REQ-013 SHALL move IDLE->WAIT when access is high and dmem_ack is low, and stay in WAIT until dmem_ack, then return to IDLE.
REQ-014 SHALL support zero-wait access: access with dmem_ack in the same IDLE cycle completes without entering WAIT.
REQ-015 SHALL drive stall_mem = access & ~dmem_ack (combinational), so it is never high in the completing cycle.
REQ-016 SHALL, on every non-stalled cycle, register ALUout->ALUout4, npc3->npc4, rd3->rd4, WBdata_EX->WBdata_MEM, RegWr_EX->RegWr_MEM.
REQ-017 SHALL capture dmem_rdata into MemData4 on the load-completing cycle, and 0 on all other non-stalled cycles.
REQ-018 SHALL insert a bubble into MEM/WB on every stalled cycle: RegWr_MEM=0, all other MEM/WB outputs hold their previous values.
REQ-019 SHALL give non-memory instructions a latency of 1 cycle through the stage, and memory instructions 1 + wait cycles.
REQ-020 SHALL ignore dmem_ack while access is low.

Reset
REQ-021 SHALL, when rst_n=0 at a clock edge, set FSM=IDLE, all MEM/WB outputs to 0, timeout counter to 0, and mem_err to 0.
REQ-022 SHALL let reset asserted in WAIT abandon the outstanding access; after release dmem_req follows REQ-012 from IDLE.

Configuration
REQ-023 SHALL use macro MEM_TIMEOUT_EN to compile in the timeout function.
REQ-024 SHALL, with MEM_TIMEOUT_EN defined, count wait cycles in WAIT; after TIMEOUT_CYCLES cycles without ack it forces completion: stall_mem low, MemData4=0, RegWr_MEM=0, mem_err set (sticky until reset), FSM->IDLE.
REQ-025 SHALL, without MEM_TIMEOUT_EN, have no counter, wait indefinitely, and tie mem_err to 0.

Structure
REQ-026 SHALL place the FSM state enum, WBdata encodings (00 ALU, 01 memory, 10 npc) and the TIMEOUT_CYCLES default in the shared pipeline package.
REQ-027 SHALL keep the MEM/WB register inline; the optional timeout counter is the single natural sub-module, mem_timeout.

Verification
REQ-028 SHALL cover ALU op with RegWr_EX=1, ALUout=0x0000_0005, rd3=3 -> next cycle RegWr_MEM=1, ALUout4=5, rd4=3, no dmem_req.
REQ-029 SHALL cover load to ALUout=0x40 with ack after 3 cycles and rdata=0xDEAD_BEEF -> dmem_req high for 4 cycles, stall_mem high for 3, MemData4=0xDEADBEEF one cycle after ack.
REQ-030 SHALL cover store to 0x80 with D=0x1234 and zero-wait ack -> dmem_we=1, dmem_wdata=0x1234, stall_mem never high, RegWr_MEM=0.
REQ-031 SHALL cover rst_n=0 during WAIT of a load -> next cycle all outputs 0, FSM IDLE; dmem_ack arriving later is ignored.
REQ-032 SHALL, with MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, cover a load never acked -> stall released after 4 wait cycles, mem_err=1 and stays 1 across later instructions.
REQ-033 SHALL cover MemRd_EX=MemWr_EX=1 -> dmem_we=1 and MemData4=0 after completion.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared pipeline definitions for the memory stage.
// FSM states, write-back source encodings, timeout default.
package memory_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_NPC = 2'b10;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef struct packed {
    logic        regwr;
    logic [1:0]  wbdata;
    logic [31:0] aluout;
    logic [31:0] memdata;
    logic [31:0] npc;
    logic [3:0]  rd;
  } mem_wb_t;

endpackage

// File: rtl/memory_stage_timeout.sv
// Wait-cycle counter for the memory stage; present only
// when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_timeout
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_wait_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          hit;

  // Fires on the last permitted wait cycle so it completes there.
  assign hit       = in_wait_i & ~ack_i & (cnt_q == LAST);
  assign timeout_o = hit;

  always_comb begin
    cnt_d = '0;
    if (in_wait_i && !ack_i && !hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/memory_stage.sv
// MEM pipeline stage: data-memory handshake and MEM/WB register.
// Optional access timeout compiled in with MEM_TIMEOUT_EN.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWr_EX,
  input  logic        MemWr_EX,
  input  logic        MemRd_EX,
  input  logic [1:0]  WBdata_EX,
  input  logic [31:0] ALUout,
  input  logic [31:0] D,
  input  logic [31:0] npc3,
  input  logic [3:0]  rd3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic        RegWr_MEM,
  output logic [1:0]  WBdata_MEM,
  output logic [31:0] ALUout4,
  output logic [31:0] MemData4,
  output logic [31:0] npc4,
  output logic [3:0]  rd4,
  output logic        mem_err
);

  mem_state_e state_q;
  mem_state_e state_d;
  mem_wb_t    wb_q;
  mem_wb_t    wb_d;

  logic access;
  logic is_load;
  logic in_wait;
  logic timeout;
  logic done;

  assign access  = MemRd_EX | MemWr_EX;
  // Store wins when both strobes are set: no read data captured.
  assign is_load = MemRd_EX & ~MemWr_EX;
  assign in_wait = (state_q == WAIT) & access;
  assign done    = access & dmem_ack;

`ifdef MEM_TIMEOUT_EN
  logic err_q;

  mem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_wait_i (in_wait),
    .ack_i     (dmem_ack),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign mem_err = err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  assign dmem_req   = access;
  assign dmem_we    = MemWr_EX;
  assign dmem_addr  = ALUout;
  assign dmem_wdata = D;
  assign stall_mem  = access & ~dmem_ack & ~timeout;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (access && !dmem_ack) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!access || dmem_ack || timeout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_d = wb_q;
    if (stall_mem) begin
      wb_d.regwr = 1'b0;
    end else begin
      wb_d.regwr   = RegWr_EX & ~timeout;
      wb_d.wbdata  = WBdata_EX;
      wb_d.aluout  = ALUout;
      wb_d.npc     = npc3;
      wb_d.rd      = rd3;
      wb_d.memdata = (is_load && done) ? dmem_rdata : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
    end
  end

  assign RegWr_MEM  = wb_q.regwr;
  assign WBdata_MEM = wb_q.wbdata;
  assign ALUout4    = wb_q.aluout;
  assign MemData4   = wb_q.memdata;
  assign npc4       = wb_q.npc;
  assign rd4        = wb_q.rd;

endmodule

// File: tb/tb_memory_stage.sv
// Directed scoreboard bench for memory_stage.
// Timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_memory_stage;

  localparam int TO = 4;

  typedef struct packed {
    logic        regwr;
    logic [1:0]  wbdata;
    logic [31:0] aluout;
    logic [31:0] memdata;
    logic [31:0] npc;
    logic [3:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWr_EX, MemWr_EX, MemRd_EX;
  logic [1:0]  WBdata_EX;
  logic [31:0] ALUout, D, npc3;
  logic [3:0]  rd3;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall_mem;
  logic        RegWr_MEM;
  logic [1:0]  WBdata_MEM;
  logic [31:0] ALUout4, MemData4, npc4;
  logic [3:0]  rd4;
  logic        mem_err;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  memory_stage #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWr_EX   (RegWr_EX),
    .MemWr_EX   (MemWr_EX),
    .MemRd_EX   (MemRd_EX),
    .WBdata_EX  (WBdata_EX),
    .ALUout     (ALUout),
    .D          (D),
    .npc3       (npc3),
    .rd3        (rd3),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .stall_mem  (stall_mem),
    .RegWr_MEM  (RegWr_MEM),
    .WBdata_MEM (WBdata_MEM),
    .ALUout4    (ALUout4),
    .MemData4   (MemData4),
    .npc4       (npc4),
    .rd4        (rd4),
    .mem_err    (mem_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RegWr_EX   = 1'b0;
    MemWr_EX   = 1'b0;
    MemRd_EX   = 1'b0;
    WBdata_EX  = 2'b00;
    ALUout     = '0;
    D          = '0;
    npc3       = '0;
    rd3        = '0;
    dmem_rdata = '0;
    dmem_ack   = 1'b0;
  endtask

  task automatic check_wb(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_regwr"}, 32'(RegWr_MEM), 32'(e.regwr));
    chk({tag, "_wbsel"}, 32'(WBdata_MEM), 32'(e.wbdata));
    chk({tag, "_alu4"}, ALUout4, e.aluout);
    chk({tag, "_mem4"}, MemData4, e.memdata);
    chk({tag, "_npc4"}, npc4, e.npc);
    chk({tag, "_rd4"}, 32'(rd4), 32'(e.rd));
    chk({tag, "_err"}, 32'(mem_err), 32'(exp_err));
  endtask

  // ack_after: cycle index (0 = same cycle) of ack; -1 = never.
  task automatic run_instr(input string tag,
                           input logic rw, input logic mw,
                           input logic mr,
                           input logic [1:0] wb,
                           input logic [31:0] alu,
                           input logic [31:0] d,
                           input logic [31:0] npc,
                           input logic [3:0] rd,
                           input int ack_after,
                           input logic [31:0] rdata,
                           input int exp_stall,
                           input logic tmo);
    exp_t e;
    int   stalls = 0;
    int   reqs = 0;
    int   cyc = 0;
    logic acc;
    acc = mr | mw;
    RegWr_EX   = rw;
    MemWr_EX   = mw;
    MemRd_EX   = mr;
    WBdata_EX  = wb;
    ALUout     = alu;
    D          = d;
    npc3       = npc;
    rd3        = rd;
    dmem_rdata = rdata;
    dmem_ack   = (ack_after == 0);
    e.regwr   = rw & ~tmo;
    e.wbdata  = wb;
    e.aluout  = alu;
    e.memdata = (mr && !mw && !tmo) ? rdata : 32'h0;
    e.npc     = npc;
    e.rd      = rd;
    exp_q.push_back(e);
    #1;
    chk({tag, "_we"}, 32'(dmem_we), 32'(mw));
    chk({tag, "_addr"}, dmem_addr, alu);
    chk({tag, "_wdata"}, dmem_wdata, d);
    forever begin
      if (dmem_req) reqs++;
      if (!stall_mem) break;
      stalls++;
      if (stalls > 64) begin
        chk({tag, "_stall_budget"}, 32'd1, 32'd0);
        break;
      end
      tick();
      chk({tag, "_bubble"}, 32'(RegWr_MEM), 32'd0);
      cyc++;
      dmem_ack = (cyc == ack_after);
      #1;
    end
    chk({tag, "_stalls"}, stalls, exp_stall);
    chk({tag, "_reqs"}, reqs, acc ? exp_stall + 1 : 0);
    tick();
    dmem_ack = 1'b0;
    check_wb(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk("rst_regwr", 32'(RegWr_MEM), 32'd0);
    chk("rst_alu4", ALUout4, 32'd0);
    chk("rst_mem4", MemData4, 32'd0);
    chk("rst_rd4", 32'(rd4), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_stall", 32'(stall_mem), 32'd0);

    run_instr("alu", 1'b1, 1'b0, 1'b0, 2'b00,
              32'h5, 32'h0, 32'h104, 4'd3,
              -1, 32'h0, 0, 1'b0);
    run_instr("load", 1'b1, 1'b0, 1'b1, 2'b01,
              32'h40, 32'h0, 32'h108, 4'd5,
              3, 32'hDEAD_BEEF, 3, 1'b0);
    run_instr("store", 1'b0, 1'b1, 1'b0, 2'b00,
              32'h80, 32'h1234, 32'h10C, 4'd0,
              0, 32'h5555_AAAA, 0, 1'b0);
    run_instr("both", 1'b0, 1'b1, 1'b1, 2'b01,
              32'hC0, 32'hCAFE, 32'h110, 4'd7,
              1, 32'hFFFF_0000, 1, 1'b0);
    run_instr("npc", 1'b1, 1'b0, 1'b0, 2'b10,
              32'h77, 32'h0, 32'h114, 4'd1,
              -1, 32'h0, 0, 1'b0);
    run_instr("ld0w", 1'b1, 1'b0, 1'b1, 2'b01,
              32'h44, 32'h0, 32'h118, 4'd9,
              0, 32'h0BAD_F00D, 0, 1'b0);

    // Reset while a load is parked in WAIT.
    RegWr_EX   = 1'b1;
    MemRd_EX   = 1'b1;
    WBdata_EX  = 2'b01;
    ALUout     = 32'h48;
    npc3       = 32'h11C;
    rd3        = 4'd4;
    dmem_rdata = 32'h1357_9BDF;
    tick();
    tick();
    chk("wait_stall", 32'(stall_mem), 32'd1);
    rst_n = 1'b0;
    idle_inputs();
    tick();
    chk("rw_regwr", 32'(RegWr_MEM), 32'd0);
    chk("rw_alu4", ALUout4, 32'd0);
    chk("rw_mem4", MemData4, 32'd0);
    chk("rw_npc4", npc4, 32'd0);
    chk("rw_rd4", 32'(rd4), 32'd0);
    chk("rw_req", 32'(dmem_req), 32'd0);
    chk("rw_stall", 32'(stall_mem), 32'd0);
    rst_n = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    tick();
    #1;
    chk("late_stall", 32'(stall_mem), 32'd0);
    chk("late_req", 32'(dmem_req), 32'd0);
    dmem_ack = 1'b0;
    tick();
    chk("late_regwr", 32'(RegWr_MEM), 32'd0);
    chk("late_mem4", MemData4, 32'd0);
    dmem_rdata = '0;

    run_instr("post", 1'b1, 1'b0, 1'b1, 2'b01,
              32'h50, 32'h0, 32'h120, 4'd6,
              2, 32'h2468_ACE0, 2, 1'b0);

`ifdef MEM_TIMEOUT_EN
    exp_err = 1'b1;
    run_instr("tmo", 1'b1, 1'b0, 1'b1, 2'b01,
              32'h60, 32'h0, 32'h124, 4'd8,
              -1, 32'h7777_7777, TO, 1'b1);
    run_instr("tmo_after", 1'b1, 1'b0, 1'b0, 2'b00,
              32'h9, 32'h0, 32'h128, 4'd2,
              -1, 32'h0, 0, 1'b0);
`endif

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
